// File: rtl/tlb_write_ctrl_pkg.sv
// Shared types and constants for the TLB maintenance controller (TLBR/TLBWI/TLBWR/TLBP).
package tlb_write_ctrl_pkg;

  localparam int TLB_ENTRIES   = 16;
  // Index port is sized for the largest supported TLB; smaller TLBs zero-extend.
  localparam int TLB_IDX_MAX_W = 6;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    TLBR  = 2'd0,
    TLBWI = 2'd1,
    TLBWR = 2'd2,
    TLBP  = 2'd3
  } tlbOp_t;

  typedef logic [TLB_IDX_MAX_W-1:0] tlbIndex_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [23:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [23:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlbEntry_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    PROBE   = 3'd4,
    FLUSH   = 3'd5
  } tlbState_t;

endpackage

// File: rtl/tlb_write_ctrl_random_gen.sv
// CP0 Random register: counts down from TLB_ENTRIES-1 to Wired, then wraps back to the top.
module tlb_random_gen
  import tlb_write_ctrl_pkg::*;
#(
  parameter int TLB_ENTRIES = tlb_write_ctrl_pkg::TLB_ENTRIES
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t wired,
  input  logic  wired_we,
  output word_t random
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] rnd_q;
  logic             wired_high;
  logic             at_wired;

  // With every entry wired there is nothing left to randomise, so park at the top.
  assign wired_high = (wired >= word_t'(TLB_ENTRIES - 1));
  assign at_wired   = ({{(32-IDX_W){1'b0}}, rnd_q} == wired);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rnd_q <= TOP_IDX;
    end else if (wired_we || wired_high || at_wired) begin
      rnd_q <= TOP_IDX;
    end else begin
      rnd_q <= rnd_q - IDX_W'(1);
    end
  end

  assign random = {{(32-IDX_W){1'b0}}, rnd_q};

endmodule

// File: rtl/tlb_write_ctrl.sv
// Sequences TLB read/write/probe operations between CP0 registers and the MMU TLB array.
module tlb_write_ctrl
  import tlb_write_ctrl_pkg::*;
#(
  parameter int TLB_ENTRIES = tlb_write_ctrl_pkg::TLB_ENTRIES
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req_valid,
  input  tlbOp_t    req_op,
  output logic      req_ready,
  input  word_t     cp0_index,
  input  word_t     cp0_wired,
  input  word_t     cp0_entry_hi,
  input  word_t     cp0_entry_lo0,
  input  word_t     cp0_entry_lo1,
  input  logic      wired_we,
  input  word_t     tlbp_index,
  output tlbIndex_t tlbrw_index,
  output logic      tlbrw_we,
  output tlbEntry_t tlbrw_wdata,
  input  tlbEntry_t tlbrw_rdata,
  output logic      index_we,
  output word_t     index_wdata,
  output logic      entry_we,
  output word_t     entry_hi_wdata,
  output word_t     entry_lo0_wdata,
  output word_t     entry_lo1_wdata,
  output word_t     random,
  output logic      pipe_flush,
  output logic      done
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);

  tlbState_t state;
  word_t     rnd_val;
  tlbEntry_t wr_entry;
  logic      unused_bits;

  function automatic tlbIndex_t ext_idx(input logic [IDX_W-1:0] idx);
    return tlbIndex_t'(idx);
  endfunction

  function automatic word_t hi_word(input logic [18:0] vpn2, input logic [7:0] asid);
    return {vpn2, 5'b0_0000, asid};
  endfunction

  function automatic word_t lo_word(input logic [23:0] pfn, input logic [2:0] c,
                                    input logic d, input logic v, input logic g);
    return {2'b00, pfn, c, d, v, g};
  endfunction

  tlb_random_gen #(
    .TLB_ENTRIES(TLB_ENTRIES)
  ) u_random_gen (
    .clk      (clk),
    .rst      (rst),
    .wired    (cp0_wired),
    .wired_we (wired_we),
    .random   (rnd_val)
  );

  assign random    = rnd_val;
  assign req_ready = (state == IDLE);

  // An entry is global only if both halves are marked global.
  always_comb begin
    wr_entry      = '0;
    wr_entry.vpn2 = cp0_entry_hi[31:13];
    wr_entry.asid = cp0_entry_hi[7:0];
    wr_entry.g    = cp0_entry_lo0[0] & cp0_entry_lo1[0];
    wr_entry.pfn0 = cp0_entry_lo0[29:6];
    wr_entry.c0   = cp0_entry_lo0[5:3];
    wr_entry.d0   = cp0_entry_lo0[2];
    wr_entry.v0   = cp0_entry_lo0[1];
    wr_entry.pfn1 = cp0_entry_lo1[29:6];
    wr_entry.c1   = cp0_entry_lo1[5:3];
    wr_entry.d1   = cp0_entry_lo1[2];
    wr_entry.v1   = cp0_entry_lo1[1];
  end

  assign unused_bits = ^{cp0_index[31:IDX_W], cp0_entry_hi[12:8], cp0_entry_lo0[31:30],
                         cp0_entry_lo1[31:30], rnd_val[31:IDX_W]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      tlbrw_index     <= '0;
      tlbrw_we        <= 1'b0;
      tlbrw_wdata     <= '0;
      index_we        <= 1'b0;
      index_wdata     <= '0;
      entry_we        <= 1'b0;
      entry_hi_wdata  <= '0;
      entry_lo0_wdata <= '0;
      entry_lo1_wdata <= '0;
      pipe_flush      <= 1'b0;
      done            <= 1'b0;
    end else begin
      tlbrw_we   <= 1'b0;
      index_we   <= 1'b0;
      entry_we   <= 1'b0;
      pipe_flush <= 1'b0;
      done       <= 1'b0;
      case (state)
        // Everything the op needs is captured here so later CP0 changes cannot leak in.
        IDLE: begin
          if (req_valid) begin
            case (req_op)
              TLBWI: begin
                state       <= WRITE;
                tlbrw_index <= ext_idx(cp0_index[IDX_W-1:0]);
                tlbrw_wdata <= wr_entry;
                tlbrw_we    <= 1'b1;
              end
              TLBWR: begin
                state       <= WRITE;
                tlbrw_index <= ext_idx(rnd_val[IDX_W-1:0]);
                tlbrw_wdata <= wr_entry;
                tlbrw_we    <= 1'b1;
              end
              TLBR: begin
                state       <= READ;
                tlbrw_index <= ext_idx(cp0_index[IDX_W-1:0]);
              end
              TLBP: begin
                state       <= PROBE;
                index_we    <= 1'b1;
                index_wdata <= tlbp_index;
                done        <= 1'b1;
              end
            endcase
          end
        end
        READ: begin
          state           <= CAPTURE;
          entry_we        <= 1'b1;
          entry_hi_wdata  <= hi_word(tlbrw_rdata.vpn2, tlbrw_rdata.asid);
          entry_lo0_wdata <= lo_word(tlbrw_rdata.pfn0, tlbrw_rdata.c0, tlbrw_rdata.d0,
                                     tlbrw_rdata.v0, tlbrw_rdata.g);
          entry_lo1_wdata <= lo_word(tlbrw_rdata.pfn1, tlbrw_rdata.c1, tlbrw_rdata.d1,
                                     tlbrw_rdata.v1, tlbrw_rdata.g);
        end
        CAPTURE, WRITE: begin
          state      <= FLUSH;
          pipe_flush <= 1'b1;
          done       <= 1'b1;
        end
        PROBE:   state <= IDLE;
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
